ahb_lite_gpio: RTL
==================

Name: ahb_lite_gpio

Overview:
- AHB-Lite slave on the SCR1 dmem bus, placed alongside the UART and ROM behind the AHB slave mux.
- Provides board ID registers, a 6-bit LED output register, debounced sampling of 5 push-buttons, and press-edge interrupts.
- Produces hrdata/hreadyout/hresp for the slave mux. Produces one IRQ line for the IPIC.

Parameters:
SOC_ID, 32'h0, value of the read-only SOC_ID register
BLD_ID, 32'h0, value of the read-only BLD_ID register
CLK_FREQ, 32'd27_000_000, value of the read-only CLK_FREQ register
BTN_ACTIVE_LOW, 1, when 1 btn_i is inverted before synchronization
DEBOUNCE_CYCLES, 16'd50000, number of stable cycles required before the debounced value changes (minimum 2)

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous reset, active-low
hsel  in  1  slave select
haddr  in  32  address; only [4:0] is decoded
htrans  in  2  transfer type
hsize  in  3  transfer size
hwrite  in  1  write strobe
hwdata  in  32  write data, valid in the data phase
hready_in  in  1  bus HREADY
hrdata  out  32  read data
hreadyout  out  1  slave ready
hresp  out  1  0 = OKAY, 1 = ERROR
btn_i  in  5  raw button pins (asynchronous)
led_o  out  6  LED drive, registered
irq_o  out  1  interrupt, registered, active-high

Behaviour:
- Reset: hrdata=0, hreadyout=1, hresp=0, led_o=0, irq_o=0, all registers=0, sync/debounce state=0, FSM=IDLE.
- Address phase is accepted when hsel & htrans[1] & hready_in. On acceptance, latch haddr[4:2], hwrite, and the lane0 flag. lane0=1 for a word access, a halfword access at haddr[1]=0, or a byte access at haddr[1:0]=0.
- Register map (word offsets):
  - 0x00 SOC_ID RO
  - 0x04 BLD_ID RO
  - 0x08 CLK_FREQ RO
  - 0x0C LED RW [5:0]
  - 0x10 BTN RO [4:0], debounced level, 1 = pressed
  - 0x14 IRQ_EN RW [4:0]
  - 0x18 IRQ_PEND RW1C [4:0]
  - 0x1C illegal
- Unused upper bits read 0.
- FSM states: IDLE, DATA, ERR1, ERR2.
  - IDLE to DATA on an accepted legal transfer.
  - IDLE to ERR1 on an accepted transfer with hsize>2 or offset 0x1C.
  - DATA: hreadyout=1, hresp=0. hrdata is driven combinationally from the latched offset. A write takes effect at the end of the data phase, only if lane0=1, using hwdata[7:0]. Writes to RO registers are ignored and complete OKAY. From DATA, go to DATA/ERR1 on a new accepted transfer, otherwise to IDLE.
  - ERR1: hreadyout=0, hresp=1. Always goes to ERR2.
  - ERR2: hreadyout=1, hresp=1. Accepts a new address phase like IDLE.
- hrdata reads 0 outside the DATA state.
- Zero wait states on OKAY. A read immediately following a write to the same register returns the new value.
- Buttons: polarity fix, then a 2-FF synchronizer, then the debouncer (see Optional Feature), then btn_db.
- A rising edge of btn_db[i] (registered previous value) sets pend[i].
- Edge set and W1C of the same bit in the same cycle: set wins.
- irq_o <= |(pend & irq_en) each cycle, so one cycle of latency from pend/en change.
- Reset asserted mid-transfer: the FSM returns to IDLE immediately and any pending write is discarded.

Optional Feature:
- Macro: SCR1_GPIO_DEBOUNCE_EN.
- Defined: one counter per button, $clog2(DEBOUNCE_CYCLES)+1 bits.
  - While the synchronized input equals btn_db[i], the counter holds at 0.
  - When they differ, the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1, btn_db[i] takes the new value and the counter clears.
  - The input returning to btn_db[i] before that clears the counter.
- Undefined: btn_db equals the synchronizer output directly (latency 2 cycles plus the edge register). No counters are instantiated.

Test Plan:
- Reset, then read 0x00/0x04/0x08 → SOC_ID/BLD_ID/CLK_FREQ. Each read gets hreadyout=1, hresp=0, zero wait.
- Word write 0x0C=32'hFFFF_FFAA, then back-to-back read 0x0C → led_o=6'h2A and hrdata=32'h2A. Byte write of 8'h05 at 0x0D → led_o unchanged.
- Read at 0x1C, then a back-to-back read at 0x00 → cycle 1: hreadyout=0, hresp=1; cycle 2: hreadyout=1, hresp=1; next data phase OKAY with SOC_ID.
- Macro defined, DEBOUNCE_CYCLES=8, BTN_ACTIVE_LOW=1:
  - Glitch btn_i[2] low for 5 cycles → BTN stays 0, no pend.
  - Hold it low for 20 cycles → BTN=5'h04, IRQ_PEND=5'h04.
  - With IRQ_EN=5'h04 written, irq_o=1 one cycle after pend.
- Write IRQ_PEND=5'h04 in the same cycle as a new press edge on bit 2 → pend[2] remains 1.
- Assert rst_n in the ERR1 cycle → next cycle hreadyout=1, hresp=0, led_o=0, irq_o=0.

Source files
------------

// File: rtl/ahb_lite_gpio.sv
// AHB-Lite GPIO slave: board ID registers, 6 LEDs, 5 debounced push-buttons with press-edge IRQ.
// Define SCR1_GPIO_DEBOUNCE_EN to put a stability counter behind each button synchronizer.
module ahb_lite_gpio #(
    parameter logic [31:0] SOC_ID          = 32'h0,
    parameter logic [31:0] BLD_ID          = 32'h0,
    parameter logic [31:0] CLK_FREQ        = 32'd27_000_000,
    parameter bit          BTN_ACTIVE_LOW  = 1'b1,
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic [2:0]  hsize,
    input  logic        hwrite,
    input  logic [31:0] hwdata,
    input  logic        hready_in,
    output logic [31:0] hrdata,
    output logic        hreadyout,
    output logic        hresp,
    input  logic [4:0]  btn_i,
    output logic [5:0]  led_o,
    output logic        irq_o
);
    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_ERR1, ST_ERR2} state_t;

    state_t      state_reg, state_next;
    logic [2:0]  offset_reg;
    logic        write_reg;
    logic        lane0_reg;
    logic [5:0]  led_reg;
    logic [4:0]  irq_en_reg;
    logic [4:0]  pend_reg, pend_next;
    logic        irq_reg;
    logic [4:0]  btn_pol, sync1_reg, sync2_reg, btn_db, btn_prev_reg, btn_rise;
    logic        accept, bad_xfer, lane0_in, wr_en;
    logic [4:0]  w1c_mask;
    logic [31:0] rd_data;
    logic        unused_bits;
    genvar       gi;

    assign unused_bits = &{1'b0, haddr[31:5], htrans[0], hwdata[31:8], DEBOUNCE_CYCLES};

    // ERR1 drives hreadyout low, so no address phase can complete in it.
    assign accept   = hsel & htrans[1] & hready_in & (state_reg != ST_ERR1);
    assign bad_xfer = (hsize > 3'd2) | (haddr[4:2] == 3'd7);
    assign lane0_in = (hsize == 3'd2)
                    | ((hsize == 3'd1) & ~haddr[1])
                    | ((hsize == 3'd0) & (haddr[1:0] == 2'b00));

    always_comb begin
        state_next = state_reg;
        hreadyout  = 1'b1;
        hresp      = 1'b0;
        case (state_reg)
            ST_ERR1: begin
                hreadyout  = 1'b0;
                hresp      = 1'b1;
                state_next = ST_ERR2;
            end
            default: begin
                hresp = (state_reg == ST_ERR2);
                if (accept) begin
                    state_next = bad_xfer ? ST_ERR1 : ST_DATA;
                end else begin
                    state_next = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            offset_reg <= 3'd0;
            write_reg  <= 1'b0;
            lane0_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                offset_reg <= haddr[4:2];
                write_reg  <= hwrite;
                lane0_reg  <= lane0_in;
            end
        end
    end

    // Every DATA cycle completes, so the write lands on the edge that ends it.
    assign wr_en     = (state_reg == ST_DATA) & write_reg & lane0_reg;
    assign w1c_mask  = (wr_en && offset_reg == 3'd6) ? hwdata[4:0] : 5'd0;
    assign pend_next = (pend_reg & ~w1c_mask) | btn_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_reg      <= 6'd0;
            irq_en_reg   <= 5'd0;
            pend_reg     <= 5'd0;
            irq_reg      <= 1'b0;
            sync1_reg    <= 5'd0;
            sync2_reg    <= 5'd0;
            btn_prev_reg <= 5'd0;
        end else begin
            if (wr_en && offset_reg == 3'd3) led_reg <= hwdata[5:0];
            if (wr_en && offset_reg == 3'd5) irq_en_reg <= hwdata[4:0];
            pend_reg     <= pend_next;
            irq_reg      <= |(pend_reg & irq_en_reg);
            sync1_reg    <= btn_pol;
            sync2_reg    <= sync1_reg;
            btn_prev_reg <= btn_db;
        end
    end

    assign btn_pol  = BTN_ACTIVE_LOW ? ~btn_i : btn_i;
    assign btn_rise = btn_db & ~btn_prev_reg;

`ifdef SCR1_GPIO_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 16'd1);

    generate
        for (gi = 0; gi < 5; gi++) begin : g_debounce
            logic [CNT_W-1:0] cnt_reg;
            logic             db_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                    db_reg  <= 1'b0;
                end else if (sync2_reg[gi] == db_reg) begin
                    cnt_reg <= '0;
                end else if (cnt_reg == CNT_LAST) begin
                    cnt_reg <= '0;
                    db_reg  <= sync2_reg[gi];
                end else begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end

            assign btn_db[gi] = db_reg;
        end
    endgenerate
`else
    generate
        for (gi = 0; gi < 5; gi++) begin : g_nodebounce
            assign btn_db[gi] = sync2_reg[gi];
        end
    endgenerate
`endif

    always_comb begin
        rd_data = 32'd0;
        if (state_reg == ST_DATA) begin
            case (offset_reg)
                3'd0:    rd_data = SOC_ID;
                3'd1:    rd_data = BLD_ID;
                3'd2:    rd_data = CLK_FREQ;
                3'd3:    rd_data = {26'd0, led_reg};
                3'd4:    rd_data = {27'd0, btn_db};
                3'd5:    rd_data = {27'd0, irq_en_reg};
                3'd6:    rd_data = {27'd0, pend_reg};
                default: rd_data = 32'd0;
            endcase
        end
    end

    assign hrdata = rd_data;
    assign led_o  = led_reg;
    assign irq_o  = irq_reg;
endmodule
